// File: rtl/fifo_rr_controller.sv
// Write-side round-robin arbiter and read-side valid/ready sequencer for a small
// synchronous FIFO, with a shadow occupancy count checked against the FIFO flags.
module fifo_rr_controller #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  level,
    output logic              last_grant,
    output logic              sync_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LVL_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LVL_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LVL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic              last_grant_r;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;
    logic [CNT_W-1:0]  level_r;
    logic [CNT_W-1:0]  level_next_s;
    logic              sync_err_r;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              wr_s;
    logic              rd_s;
    logic              mismatch_s;

    // Round-robin grant: on a tie the requester that did not win last time goes
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (fifo_full) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            case ({a_valid, b_valid})
                2'b10: grant_a_s = 1'b1;
                2'b01: grant_b_s = 1'b1;
                2'b11: begin
                    grant_a_s = last_grant_r;
                    grant_b_s = ~last_grant_r;
                end
                default: begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
            endcase
        end
    end

    assign wr_s = grant_a_s | grant_b_s;

    // Read strobe: issued from IDLE or from HOLD once the consumer takes the word
    always_comb begin
        rd_s = 1'b0;
        case (state_r)
            ST_IDLE: rd_s = ~fifo_empty;
            ST_HOLD: rd_s = m_ready & ~fifo_empty;
            default: rd_s = 1'b0;
        endcase
    end

    // Shadow occupancy next value, clamped so a flag fault cannot wrap the count
    always_comb begin
        level_next_s = level_r;
        if (wr_s && !rd_s && (level_r != LVL_MAX)) begin
            level_next_s = level_r + LVL_ONE;
        end else if (rd_s && !wr_s && (level_r != LVL_ZERO)) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    assign mismatch_s = ((level_r == LVL_MAX) != fifo_full) ||
                        ((level_r == LVL_ZERO) != fifo_empty);

    // Read sequencer: fetch one word, then hold it until the consumer accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    m_data_r  <= fifo_rd_data;
                    m_valid_r <= 1'b1;
                    state_r   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid_r <= 1'b0;
                        state_r   <= fifo_empty ? ST_IDLE : ST_FETCH;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Arbitration history, shadow level and sticky flag-disagreement detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            level_r      <= LVL_ZERO;
            sync_err_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                last_grant_r <= grant_b_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            level_r    <= level_next_s;
            sync_err_r <= sync_err_r | mismatch_s;
        end
    end

    assign a_ready      = grant_a_s;
    assign b_ready      = grant_b_s;
    assign fifo_wr_en   = wr_s;
    assign fifo_wr_data = grant_a_s ? a_data : (grant_b_s ? b_data : {DATA_W{1'b0}});
    assign fifo_rd_en   = rd_s;
    assign m_valid      = m_valid_r;
    assign m_data       = m_data_r;
    assign level        = level_r;
    assign last_grant   = last_grant_r;
    assign sync_err     = sync_err_r;

endmodule
